// File: rtl/pinwheel_bus_pkg.sv
// Shared types and constants for the pinwheel data-bus fabric.
// Arbiter states, requester ids, address tags and the read-return pipe record.
package pinwheel_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } arb_state_t;

  typedef logic port_id_t;

  localparam port_id_t PORT_A = 1'b0;
  localparam port_id_t PORT_B = 1'b1;

  localparam logic [3:0] TAG_CODE  = 4'h0;
  localparam logic [3:0] TAG_DATA  = 4'h8;
  localparam logic [3:0] TAG_DEBUG = 4'hF;

  localparam int LOCK_CNT_W = 8;

  typedef struct packed {
    logic     valid;
    port_id_t owner;
    logic     err;
  } rsp_pipe_t;

  function automatic logic [3:0] addr_tag(input logic [31:0] addr);
    return addr[31:28];
  endfunction

  function automatic arb_state_t own_state(input port_id_t id);
    return (id == PORT_A) ? OWN_A : OWN_B;
  endfunction

endpackage

// File: rtl/data_bus_arbiter_if.sv
// Bundle of both requester ports plus the block_ram side of the data-bus arbiter.
// Handshake: a request transfers on the cycle where x_req_valid && x_req_ready; the requester
// holds valid and payload stable until ready, and ready never waits on anything but the grant.
interface data_bus_arbiter_if #(
  parameter int ADDR_BITS = 12
);

  logic                 a_req_valid, b_req_valid;
  logic [31:0]          a_req_addr,  b_req_addr;
  logic                 a_req_wren,  b_req_wren;
  logic [3:0]           a_req_wmask, b_req_wmask;
  logic [31:0]          a_req_wdata, b_req_wdata;
  logic                 a_req_lock,  b_req_lock;
  logic                 a_req_ready, b_req_ready;
  logic                 a_rsp_valid, b_rsp_valid;
  logic [31:0]          a_rsp_rdata, b_rsp_rdata;
  logic                 a_rsp_err,   b_rsp_err;

  logic [ADDR_BITS-1:0] ram_addr;
  logic                 ram_cs;
  logic [31:0]          ram_wdata;
  logic [3:0]           ram_wmask;
  logic                 ram_wren;
  logic [31:0]          ram_rdata;

  modport slave (
    input  a_req_valid, a_req_addr, a_req_wren, a_req_wmask, a_req_wdata, a_req_lock,
    input  b_req_valid, b_req_addr, b_req_wren, b_req_wmask, b_req_wdata, b_req_lock,
    output a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err,
    output b_req_ready, b_rsp_valid, b_rsp_rdata, b_rsp_err,
    output ram_addr, ram_cs, ram_wdata, ram_wmask, ram_wren,
    input  ram_rdata
  );

  modport master (
    output a_req_valid, a_req_addr, a_req_wren, a_req_wmask, a_req_wdata, a_req_lock,
    output b_req_valid, b_req_addr, b_req_wren, b_req_wmask, b_req_wdata, b_req_lock,
    input  a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err,
    input  b_req_ready, b_rsp_valid, b_rsp_rdata, b_rsp_err,
    input  ram_addr, ram_cs, ram_wdata, ram_wmask, ram_wren,
    output ram_rdata
  );

endinterface

// File: rtl/data_bus_arbiter_rr_grant2.sv
// Two-way round-robin pick: when both ports want the bus, the one not granted last wins.
module rr_grant2
  import pinwheel_bus_pkg::*;
(
  input  logic [1:0] valid,
  input  port_id_t   last_grant,
  output port_id_t   grant
);

  always_comb begin
    grant = last_grant;
    if (valid == 2'b11) begin
      grant = (last_grant == PORT_A) ? PORT_B : PORT_A;
    end else if (valid[0]) begin
      grant = PORT_A;
    end else if (valid[1]) begin
      grant = PORT_B;
    end
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// Shares the single-port data block_ram between the core (port A) and the debug/DMA loader (port B).
// Round-robin with locked bursts, a bounded lock counter and a one-cycle read-return pipe.
module data_bus_arbiter
  import pinwheel_bus_pkg::*;
#(
  parameter int         ADDR_BITS = 12,
  parameter int         LOCK_MAX  = 16,
  parameter logic [3:0] RAM_TAG   = TAG_DATA
) (
  input  logic                  clock,
  input  logic                  reset_n_in,
  data_bus_arbiter_if.slave     bus,
  output arb_state_t            dbg_state,
  output logic [LOCK_CNT_W-1:0] dbg_lock_cnt
);

  localparam logic [LOCK_CNT_W-1:0] CNT_MAX = LOCK_CNT_W'(LOCK_MAX);
  localparam logic [LOCK_CNT_W-1:0] CNT_ONE = LOCK_CNT_W'(1);

  arb_state_t            state_q, state_d;
  port_id_t              last_q, last_d;
  logic [LOCK_CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  rsp_pipe_t             rsp_q, rsp_d;

  port_id_t    rr_id, gnt_id;
  logic        gnt_valid, accept, other_valid, tag_hit;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_wmask;
  logic        sel_wren, sel_lock;

  rr_grant2 u_rr (
    .valid      ({bus.b_req_valid, bus.a_req_valid}),
    .last_grant (last_q),
    .grant      (rr_id)
  );

  // Grant owner: round-robin in IDLE, otherwise pinned to the burst owner.
  always_comb begin
    gnt_id    = rr_id;
    gnt_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_id    = rr_id;
        gnt_valid = bus.a_req_valid | bus.b_req_valid;
      end
      OWN_A: begin
        gnt_id    = PORT_A;
        gnt_valid = bus.a_req_valid;
      end
      OWN_B: begin
        gnt_id    = PORT_B;
        gnt_valid = bus.b_req_valid;
      end
      default: begin
        gnt_id    = rr_id;
        gnt_valid = 1'b0;
      end
    endcase
  end

  // Reset is synchronous, so the accept path is gated to keep outputs quiet while it is held.
  assign accept      = gnt_valid && reset_n_in;
  assign other_valid = (gnt_id == PORT_A) ? bus.b_req_valid : bus.a_req_valid;

  always_comb begin
    sel_addr  = bus.a_req_addr;
    sel_wdata = bus.a_req_wdata;
    sel_wmask = bus.a_req_wmask;
    sel_wren  = bus.a_req_wren;
    sel_lock  = bus.a_req_lock;
    if (gnt_id == PORT_B) begin
      sel_addr  = bus.b_req_addr;
      sel_wdata = bus.b_req_wdata;
      sel_wmask = bus.b_req_wmask;
      sel_wren  = bus.b_req_wren;
      sel_lock  = bus.b_req_lock;
    end
  end

  assign tag_hit = (addr_tag(sel_addr) == RAM_TAG);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    rsp_d   = '0;
    cnt_inc = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;

    if (accept) begin
      rsp_d.valid = !sel_wren;
      rsp_d.owner = gnt_id;
      rsp_d.err   = !tag_hit;
    end

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          last_d = gnt_id;
          if (sel_lock && !(CNT_ONE == CNT_MAX && other_valid)) begin
            state_d = own_state(gnt_id);
            cnt_d   = CNT_ONE;
          end
        end
      end
      OWN_A, OWN_B: begin
        if (!accept) begin
          state_d = IDLE;
          last_d  = gnt_id;
        end else begin
          cnt_d = cnt_inc;
          // Forced handover only matters when the other side is actually waiting.
          if (!sel_lock || (cnt_inc == CNT_MAX && other_valid)) begin
            state_d = IDLE;
            last_d  = gnt_id;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n_in) begin
      state_q <= IDLE;
      last_q  <= PORT_B;
      cnt_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rsp_q   <= rsp_d;
    end
  end

  assign bus.a_req_ready = accept && (gnt_id == PORT_A);
  assign bus.b_req_ready = accept && (gnt_id == PORT_B);

  assign bus.ram_cs    = accept && tag_hit;
  assign bus.ram_wren  = bus.ram_cs && sel_wren;
  assign bus.ram_addr  = sel_addr[ADDR_BITS+1:2];
  assign bus.ram_wdata = sel_wdata;
  assign bus.ram_wmask = sel_wmask;

  logic rsp_live, rsp_to_a, rsp_to_b;
  assign rsp_live = rsp_q.valid && reset_n_in;
  assign rsp_to_a = rsp_live && (rsp_q.owner == PORT_A);
  assign rsp_to_b = rsp_live && (rsp_q.owner == PORT_B);

  assign bus.a_rsp_valid = rsp_to_a;
  assign bus.b_rsp_valid = rsp_to_b;
  assign bus.a_rsp_err   = rsp_to_a && rsp_q.err;
  assign bus.b_rsp_err   = rsp_to_b && rsp_q.err;
  assign bus.a_rsp_rdata = (rsp_to_a && !rsp_q.err) ? bus.ram_rdata : 32'h0;
  assign bus.b_rsp_rdata = (rsp_to_b && !rsp_q.err) ? bus.ram_rdata : 32'h0;

  assign dbg_state    = state_q;
  assign dbg_lock_cnt = cnt_q;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{sel_addr[1:0], sel_addr[27:ADDR_BITS+2]};

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Directed bench for data_bus_arbiter with a behavioural block_ram and a read-return queue.
module tb_data_bus_arbiter;
  import pinwheel_bus_pkg::*;

  logic                  clock;
  logic                  reset_n_in;
  arb_state_t            dbg_state;
  logic [LOCK_CNT_W-1:0] dbg_lock_cnt;

  data_bus_arbiter_if #(.ADDR_BITS(12)) bus ();

  data_bus_arbiter #(.ADDR_BITS(12), .LOCK_MAX(16), .RAM_TAG(4'h8)) dut (
    .clock        (clock),
    .reset_n_in   (reset_n_in),
    .bus          (bus),
    .dbg_state    (dbg_state),
    .dbg_lock_cnt (dbg_lock_cnt)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // behavioural block_ram: byte-masked writes, registered reads
  logic [31:0] mem [0:4095];
  always @(posedge clock) begin
    if (bus.ram_cs) begin
      if (bus.ram_wren) begin
        for (int k = 0; k < 4; k++)
          if (bus.ram_wmask[k]) mem[bus.ram_addr][k*8 +: 8] <= bus.ram_wdata[k*8 +: 8];
      end else begin
        bus.ram_rdata <= mem[bus.ram_addr];
      end
    end
  end

  // scoreboard
  int vec_cnt = 0;
  int err_cnt = 0;
  logic [32:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [31:0] addr, input logic wren,
                         input logic [3:0] wmask, input logic [31:0] wdata, input logic lock);
    bus.a_req_valid = v;  bus.a_req_addr = addr;  bus.a_req_wren = wren;
    bus.a_req_wmask = wmask;  bus.a_req_wdata = wdata;  bus.a_req_lock = lock;
  endtask

  task automatic drive_b(input logic v, input logic [31:0] addr, input logic wren,
                         input logic [3:0] wmask, input logic [31:0] wdata, input logic lock);
    bus.b_req_valid = v;  bus.b_req_addr = addr;  bus.b_req_wren = wren;
    bus.b_req_wmask = wmask;  bus.b_req_wdata = wdata;  bus.b_req_lock = lock;
  endtask

  task automatic idle_both();
    drive_a(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
    drive_b(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
  endtask

  task automatic pulse_reset();
    reset_n_in = 1'b0;
    cyc();
    reset_n_in = 1'b1;
  endtask

  // pops the next expected {port, data} and compares with the live response
  task automatic check_rsp(input string tag);
    logic [32:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_qempty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, {30'h0, bus.b_rsp_valid, bus.a_rsp_valid}, e[32] ? 32'd2 : 32'd1);
      check({tag, "_rdata"}, e[32] ? bus.b_rsp_rdata : bus.a_rsp_rdata, e[31:0]);
    end
  endtask

  initial begin
    int a_idx, b_idx, bw, b_before_a, b_after_a, max_cnt;
    logic a_done, a_pend, b_rsp_seen, b_wr_ok;

    for (int i = 0; i < 4096; i++) mem[i] = 32'hC0DE_0000 + i;
    mem[4] = 32'h1234_5678;
    bus.ram_rdata = 32'h0;
    idle_both();

    // reset state
    reset_n_in = 1'b0;
    drive_a(1'b1, 32'h8000_0000, 1'b0, 4'h0, 32'h0, 1'b0);
    cyc();
    cyc();
    #2;
    check("rst_a_ready", {31'h0, bus.a_req_ready}, 32'd0);
    check("rst_ram_cs", {31'h0, bus.ram_cs}, 32'd0);
    check("rst_state", {30'h0, dbg_state}, {30'h0, IDLE});
    check("rst_lock_cnt", 32'(dbg_lock_cnt), 32'd0);
    check("rst_rsp", {30'h0, bus.a_rsp_valid, bus.b_rsp_valid}, 32'd0);
    idle_both();
    cyc();
    reset_n_in = 1'b1;

    // single A read from word 4
    drive_a(1'b1, 32'h8000_0010, 1'b0, 4'h0, 32'h0, 1'b0);
    #2;
    check("rd_a_ready", {31'h0, bus.a_req_ready}, 32'd1);
    check("rd_ram_cs", {31'h0, bus.ram_cs}, 32'd1);
    check("rd_ram_addr", 32'(bus.ram_addr), 32'd4);
    check("rd_ram_wren", {31'h0, bus.ram_wren}, 32'd0);
    cyc();
    idle_both();
    #2;
    check("rd_a_rsp_valid", {31'h0, bus.a_rsp_valid}, 32'd1);
    check("rd_a_rdata", bus.a_rsp_rdata, 32'h1234_5678);
    check("rd_a_err", {31'h0, bus.a_rsp_err}, 32'd0);
    check("rd_b_rsp_valid", {31'h0, bus.b_rsp_valid}, 32'd0);
    cyc();

    // alternating unlocked reads, A words 8.., B words 16..
    pulse_reset();
    a_idx = 0;
    b_idx = 0;
    for (int i = 0; i < 6; i++) begin
      drive_a(1'b1, 32'h8000_0020 + 32'(a_idx * 4), 1'b0, 4'h0, 32'h0, 1'b0);
      drive_b(1'b1, 32'h8000_0040 + 32'(b_idx * 4), 1'b0, 4'h0, 32'h0, 1'b0);
      #2;
      check($sformatf("rr_a_ready%0d", i), {31'h0, bus.a_req_ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
      check($sformatf("rr_b_ready%0d", i), {31'h0, bus.b_req_ready}, (i % 2 == 1) ? 32'd1 : 32'd0);
      if (i > 0) check_rsp($sformatf("rr_rsp%0d", i));
      if (bus.a_req_ready) begin
        exp_q.push_back({1'b0, 32'hC0DE_0008 + 32'(a_idx)});
        a_idx++;
      end
      if (bus.b_req_ready) begin
        exp_q.push_back({1'b1, 32'hC0DE_0010 + 32'(b_idx)});
        b_idx++;
      end
      cyc();
    end
    idle_both();
    #2;
    check_rsp("rr_rsp6");
    check("rr_q_drained", 32'(exp_q.size()), 32'd0);
    cyc();

    // B locked 20-word burst against a waiting A read
    bw = 0;  b_before_a = 0;  b_after_a = 0;  max_cnt = 0;
    a_done = 1'b0;  a_pend = 1'b0;  b_rsp_seen = 1'b0;  b_wr_ok = 1'b1;
    for (int c = 0; c < 40; c++) begin
      drive_b(bw < 20, 32'h8000_0100 + 32'(bw * 4), 1'b1, 4'hF, 32'hB000_0000 + 32'(bw), 1'b1);
      drive_a(c >= 1 && !a_done, 32'h8000_0050, 1'b0, 4'h0, 32'h0, 1'b0);
      #2;
      if (int'(dbg_lock_cnt) > max_cnt) max_cnt = int'(dbg_lock_cnt);
      if (bus.b_rsp_valid) b_rsp_seen = 1'b1;
      if (a_pend) begin
        check("burst_a_rsp_valid", {31'h0, bus.a_rsp_valid}, 32'd1);
        check("burst_a_rdata", bus.a_rsp_rdata, 32'hC0DE_0014);
        a_pend = 1'b0;
      end
      if (bus.b_req_ready) begin
        if (!(bus.ram_cs && bus.ram_wren)) b_wr_ok = 1'b0;
        bw++;
        if (a_done) b_after_a++;
        else b_before_a++;
      end
      if (bus.a_req_ready) begin
        a_done = 1'b1;
        a_pend = 1'b1;
      end
      cyc();
    end
    idle_both();
    check("burst_b_total", 32'(bw), 32'd20);
    check("burst_b_before_a", 32'(b_before_a), 32'd16);
    check("burst_b_after_a", 32'(b_after_a), 32'd4);
    check("burst_a_granted", {31'h0, a_done}, 32'd1);
    check("burst_max_cnt", 32'(max_cnt), 32'd16);
    check("burst_b_no_rsp", {31'h0, b_rsp_seen}, 32'd0);
    check("burst_ram_wr", {31'h0, b_wr_ok}, 32'd1);
    check("burst_mem_last", mem[64 + 19], 32'hB000_0013);
    cyc();

    // non-RAM tags: read returns an error, write vanishes
    drive_a(1'b1, 32'h4000_0000, 1'b0, 4'h0, 32'h0, 1'b0);
    #2;
    check("err_rd_ready", {31'h0, bus.a_req_ready}, 32'd1);
    check("err_rd_ram_cs", {31'h0, bus.ram_cs}, 32'd0);
    cyc();
    idle_both();
    #2;
    check("err_rsp_valid", {31'h0, bus.a_rsp_valid}, 32'd1);
    check("err_rsp_err", {31'h0, bus.a_rsp_err}, 32'd1);
    check("err_rsp_rdata", bus.a_rsp_rdata, 32'h0);
    cyc();
    drive_a(1'b1, 32'hF000_0000, 1'b1, 4'hF, 32'h5555_5555, 1'b0);
    #2;
    check("err_wr_ready", {31'h0, bus.a_req_ready}, 32'd1);
    check("err_wr_ram_cs", {31'h0, bus.ram_cs}, 32'd0);
    cyc();
    idle_both();
    #2;
    check("err_wr_no_rsp", {31'h0, bus.a_rsp_valid}, 32'd0);
    cyc();

    // reset lands while a locked B read is in flight
    drive_b(1'b1, 32'h8000_0020, 1'b0, 4'h0, 32'h0, 1'b1);
    #2;
    check("rst_mid_b_ready", {31'h0, bus.b_req_ready}, 32'd1);
    cyc();
    reset_n_in = 1'b0;
    #2;
    check("rst_mid_b_rsp", {31'h0, bus.b_rsp_valid}, 32'd0);
    check("rst_mid_ram_cs", {31'h0, bus.ram_cs}, 32'd0);
    cyc();
    reset_n_in = 1'b1;
    drive_a(1'b1, 32'h8000_0000, 1'b0, 4'h0, 32'h0, 1'b0);
    drive_b(1'b1, 32'h8000_0004, 1'b0, 4'h0, 32'h0, 1'b0);
    #2;
    check("rst_mid_state", {30'h0, dbg_state}, {30'h0, IDLE});
    check("rst_mid_b_rsp2", {31'h0, bus.b_rsp_valid}, 32'd0);
    check("rst_mid_a_first", {30'h0, bus.b_req_ready, bus.a_req_ready}, 32'd1);
    cyc();
    idle_both();
    cyc();

    // masked write pass-through
    drive_a(1'b1, 32'h8000_0008, 1'b1, 4'b0101, 32'hAABB_CCDD, 1'b0);
    #2;
    check("wr_ready", {31'h0, bus.a_req_ready}, 32'd1);
    check("wr_ram_addr", 32'(bus.ram_addr), 32'd2);
    check("wr_ram_wren", {31'h0, bus.ram_wren}, 32'd1);
    check("wr_ram_wmask", {28'h0, bus.ram_wmask}, 32'h5);
    check("wr_ram_wdata", bus.ram_wdata, 32'hAABB_CCDD);
    cyc();
    idle_both();
    #2;
    check("wr_no_rsp", {31'h0, bus.a_rsp_valid}, 32'd0);
    check("wr_mem", mem[2], 32'hC0BB_00DD);
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
